demo2_mem_arbiter: RTL

//  Shares one synchronous single-port RAM (2**ADDR_BITS x DATA_BITS, 1-cycle read latency) between NREQ requesters.

---
 rtl/demo2_pkg.sv | 24 ++
 rtl/demo2_rr_pick.sv | 40 ++++
 rtl/demo2_mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/demo2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demo2_pkg
// Description : Shared FSM encoding, default widths and helpers for the
//               demo2 memory arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package demo2_pkg;

  localparam int DEF_ADDR_BITS = 5;
  localparam int DEF_DATA_BITS = 32;
  localparam int DEF_NREQ      = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_SERVE = 1'b0;
  localparam state_t ST_SCRUB = 1'b1;

  // Pointer width that stays legal for any NREQ >= 1
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demo2_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : demo2_rr_pick
// Description : Combinational round-robin picker: first valid bit at or
//               after ptr (mod NREQ) -> one-hot grant plus its index.
// Revision    : 1.0  initial release
// ============================================================================
module demo2_rr_pick
  import demo2_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = ptr_bits(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Scan farthest-first so the nearest valid requester overwrites the result
  always_comb begin
    int w_j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = (int'(ptr) + k) % NREQ;
      if (valid[w_j]) begin
        grant      = '0;
        grant[w_j] = 1'b1;
        idx        = PW'(w_j);
        any        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/demo2_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : demo2_mem_arbiter
// Description : Round-robin arbiter sharing one single-port sync RAM between
//               NREQ requesters, with written-bitmap and on-demand scrub.
// Revision    : 1.0  initial release
// ============================================================================
module demo2_mem_arbiter
  import demo2_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int NREQ      = DEF_NREQ
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*ADDR_BITS-1:0] req_addr,
  input  logic [NREQ*DATA_BITS-1:0] req_wdata,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DATA_BITS-1:0]      rsp_data,
  output logic                      rsp_unwr,
  input  logic                      scrub,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic [DATA_BITS-1:0]      mem_wdata,
  input  logic [DATA_BITS-1:0]      mem_rdata
);

  localparam int C_DEPTH = 2 ** ADDR_BITS;
  localparam int C_PW    = ptr_bits(NREQ);

  state_t               r_state;
  logic [C_PW-1:0]      r_rr_ptr;
  logic [C_DEPTH-1:0]   r_written;
  logic [ADDR_BITS:0]   r_scrub_cnt;
  logic [NREQ-1:0]      r_rsp_valid;
  logic                 r_rsp_unwr;

  logic                 w_serve;
  logic                 w_busy;
  logic                 w_grant_en;
  logic [NREQ-1:0]      w_grant;
  logic [C_PW-1:0]      w_idx;
  logic                 w_any;
  logic                 w_sel_we;
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic [DATA_BITS-1:0] w_sel_wdata;
  logic                 w_read_acc;
  logic                 w_scrub_last;

  // Grants are suppressed while rst is held so req_ready shows its reset value
  assign w_serve    = (r_state == ST_SERVE) && !rst;
  assign w_busy     = (r_state == ST_SCRUB);
  assign w_grant_en = w_serve && !scrub;

  demo2_rr_pick #(
    .NREQ (NREQ),
    .PW   (C_PW)
  ) u_pick (
    .valid (req_valid & {NREQ{w_grant_en}}),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  assign w_sel_we     = req_we[w_idx];
  assign w_sel_addr   = req_addr[int'(w_idx)*ADDR_BITS +: ADDR_BITS];
  assign w_sel_wdata  = req_wdata[int'(w_idx)*DATA_BITS +: DATA_BITS];
  assign w_read_acc   = w_any && !w_sel_we;
  assign w_scrub_last = (r_scrub_cnt == (ADDR_BITS+1)'(C_DEPTH - 1));

  assign req_ready = w_grant;
  assign busy      = w_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_unwr  = r_rsp_unwr;
  assign rsp_data  = (|r_rsp_valid) ? mem_rdata : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_busy) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = r_scrub_cnt[ADDR_BITS-1:0];
    end else if (w_any) begin
      mem_en    = 1'b1;
      mem_we    = w_sel_we;
      mem_addr  = w_sel_addr;
      mem_wdata = w_sel_we ? w_sel_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SERVE;
      r_rr_ptr    <= '0;
      r_written   <= '0;
      r_scrub_cnt <= '0;
      r_rsp_valid <= '0;
      r_rsp_unwr  <= 1'b0;
    end else begin
      r_rsp_valid <= w_read_acc ? w_grant : '0;
      r_rsp_unwr  <= w_read_acc && !r_written[w_sel_addr];
      case (r_state)
        ST_SERVE: begin
          if (scrub) begin
            r_state     <= ST_SCRUB;
            r_scrub_cnt <= '0;
          end else if (w_any) begin
            r_rr_ptr <= (w_idx == C_PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            if (w_sel_we) begin
              r_written[w_sel_addr] <= 1'b1;
            end
          end
        end
        ST_SCRUB: begin
          if (w_scrub_last) begin
            r_written   <= '0;
            r_scrub_cnt <= '0;
            r_state     <= ST_SERVE;
          end else begin
            r_scrub_cnt <= r_scrub_cnt + 1'b1;
          end
        end
        default: r_state <= ST_SERVE;
      endcase
    end
  end

endmodule
`default_nettype wire
